// File: rtl/mem_msgs.sv
// Shared cache<->memory message formats and type encodings for word-granularity traffic.
// Helper len_to_be turns a request length into the byte lanes it writes.
// No timing or backpressure of its own; types only.
package mem_msgs;

  localparam logic [2:0] MEM_READ  = 3'd0;
  localparam logic [2:0] MEM_WRITE = 3'd1;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  // len 0 means a full word; len n writes the low n bytes
  function automatic logic [3:0] len_to_be(input logic [1:0] len);
    case (len)
      2'd1:    len_to_be = 4'b0001;
      2'd2:    len_to_be = 4'b0011;
      2'd3:    len_to_be = 4'b0111;
      default: len_to_be = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/cache_mem_responder_array.sv
// NUM_WORDS x 32 word store: byte-enable write port, full-word backdoor port, registered read.
// Latency: rd_data valid the cycle after ren; it holds its value while ren is low.
// Backpressure: none, every port is accepted each cycle; contents survive reset.
module cache_mem_responder_array #(
  parameter int NUM_WORDS = 256,
  parameter int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic             clk,
  input  logic             init_wen,
  input  logic [IDX_W-1:0] init_idx,
  input  logic [31:0]      init_data,
  input  logic             wen,
  input  logic [3:0]       wbe,
  input  logic [IDX_W-1:0] widx,
  input  logic [31:0]      wdata,
  input  logic             ren,
  input  logic [IDX_W-1:0] ridx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [NUM_WORDS];

  // Backdoor lands first so a same-edge request write overrides it and a read forwards it.
  always_ff @(posedge clk) begin
    if (init_wen) mem[init_idx] <= init_data;
    if (wen) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (ren) rd_data <= (init_wen && init_idx == ridx) ? init_data : mem[ridx];
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory responder for cache tests; one request outstanding, optional CACHE_MEM_RESPONDER_RAND_STALL_EN stalls.
// Latency: response valid LATENCY edges after accept (LATENCY==1 responds right after the accept edge).
// Backpressure: memresp_msg held until memresp_rdy; memreq_rdy only in IDLE, never on the handshake edge.
module cache_mem_responder
  import mem_msgs::*;
#(
  parameter int NUM_WORDS = 256,
  parameter int LATENCY   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memreq_val,
  output logic         memreq_rdy,
  input  mem_req_4B_t  memreq_msg,
  output logic         memresp_val,
  input  logic         memresp_rdy,
  output mem_resp_4B_t memresp_msg,
  input  logic         init_wen,
  input  logic [31:0]  init_addr,
  input  logic [31:0]  init_data
);

  localparam int IDX_W = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_n;
  logic [3:0]  lat_cnt, lat_cnt_n;
  mem_req_4B_t req_q, req_n, acc_msg;
  logic        access, acc_is_wr, init_we, stall_req, stall_resp;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0] rd_data;
  logic        unused_bits;

`ifdef CACHE_MEM_RESPONDER_RAND_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall_req  = lfsr[1];
  assign stall_resp = lfsr[0];
`else
  assign stall_req  = 1'b0;
  assign stall_resp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      lat_cnt <= '0;
      req_q   <= '0;
    end else begin
      state   <= state_n;
      lat_cnt <= lat_cnt_n;
      req_q   <= req_n;
    end
  end

  always_comb begin
    state_n     = state;
    lat_cnt_n   = lat_cnt;
    req_n       = req_q;
    memreq_rdy  = 1'b0;
    memresp_val = 1'b0;
    access      = 1'b0;
    case (state)
      IDLE: begin
        memreq_rdy = ~stall_req;
        if (memreq_val && memreq_rdy) begin
          req_n = memreq_msg;
          if (LATENCY == 1) begin
            state_n = RESP;
            access  = 1'b1;
          end else begin
            state_n   = WAIT;
            lat_cnt_n = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (lat_cnt == 4'd0) begin
          state_n = RESP;
          access  = 1'b1;
        end else begin
          lat_cnt_n = lat_cnt - 4'd1;
        end
      end
      RESP: begin
        memresp_val = ~stall_resp;
        if (memresp_val && memresp_rdy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Reset drops any in-flight access, including one due on this very edge.
    if (reset) begin
      memreq_rdy  = 1'b1;
      memresp_val = 1'b0;
      access      = 1'b0;
    end
  end

  // On a LATENCY==1 accept the live request is accessed; otherwise the latched one.
  assign acc_msg   = (state == IDLE) ? memreq_msg : req_q;
  assign acc_is_wr = (acc_msg.type_ == MEM_WRITE);
  assign acc_idx   = acc_msg.addr[IDX_W+1:2];
  assign init_we   = init_wen && (state == IDLE) && !reset;

  cache_mem_responder_array #(
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk       (clk),
    .init_wen  (init_we),
    .init_idx  (init_addr[IDX_W+1:2]),
    .init_data (init_data),
    .wen       (access && acc_is_wr),
    .wbe       (len_to_be(acc_msg.len)),
    .widx      (acc_idx),
    .wdata     (acc_msg.data),
    .ren       (access && !acc_is_wr),
    .ridx      (acc_idx),
    .rd_data   (rd_data)
  );

  always_comb begin
    memresp_msg = '0;
    if (state == RESP && !reset) begin
      memresp_msg.type_  = req_q.type_;
      memresp_msg.opaque = req_q.opaque;
      memresp_msg.len    = req_q.len;
      memresp_msg.data   = (req_q.type_ == MEM_WRITE) ? 32'd0 : rd_data;
    end
  end

  assign unused_bits = ^{acc_msg.addr[31:IDX_W+2], acc_msg.addr[1:0], acc_msg.opaque,
                         init_addr[31:IDX_W+2], init_addr[1:0]};

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: directed vector table, reset/backdoor corner sequences,
// then random traffic checked against a word-array reference model.
module tb_cache_mem_responder;
  import mem_msgs::*;

  localparam int NW  = 256;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         memreq_val = 1'b0;
  logic         memreq_rdy;
  mem_req_4B_t  memreq_msg = '0;
  logic         memresp_val;
  logic         memresp_rdy = 1'b0;
  mem_resp_4B_t memresp_msg;
  logic         init_wen = 1'b0;
  logic [31:0]  init_addr = '0;
  logic [31:0]  init_data = '0;

  always #5 clk = ~clk;

  cache_mem_responder #(.NUM_WORDS(NW), .LATENCY(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memreq_msg  (memreq_msg),
    .memresp_val (memresp_val),
    .memresp_rdy (memresp_rdy),
    .memresp_msg (memresp_msg),
    .init_wen    (init_wen),
    .init_addr   (init_addr),
    .init_data   (init_data)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] model [NW];

  typedef struct {
    logic [2:0]  t;
    logic [7:0]  op;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
    int          stall;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % NW);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [1:0] len, input logic [31:0] d);
    int n;
    n = (len == 2'd0) ? 4 : int'(len);
    for (int b = 0; b < n; b++) model[widx(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    init_wen = 1'b1; init_addr = a; init_data = d;
    tick;
    init_wen = 1'b0;
    model[widx(a)] = d;
  endtask

  // One full request/response; an init_wen raised by the caller rides the accept edge.
  task automatic transact(input string tag, input logic [2:0] t, input logic [7:0] op,
                          input logic [31:0] a, input logic [1:0] len, input logic [31:0] d,
                          input int stall, input logic [31:0] exp_data, input bit bd_in_wait);
    mem_resp_4B_t exp;
    int cnt;
    exp = '0;
    exp.type_ = t; exp.opaque = op; exp.len = len; exp.data = exp_data;
    check({tag, ":idle_rdy"}, 64'(memreq_rdy), 64'd1);
    memreq_val = 1'b1;
    memreq_msg = '{type_: t, opaque: op, addr: a, len: len, data: d};
    tick;
    memreq_val = 1'b0; memreq_msg = '0; init_wen = 1'b0;
    if (bd_in_wait) begin
      init_wen = 1'b1; init_addr = a; init_data = ~exp_data;
    end
    cnt = 0;
    while (!memresp_val && cnt < 40) begin
      check({tag, ":busy_rdy"}, 64'(memreq_rdy), 64'd0);
      tick;
      init_wen = 1'b0;
      cnt++;
    end
    check({tag, ":latency"}, 64'(cnt), 64'(LAT));
    check({tag, ":msg"}, 64'(memresp_msg), 64'(exp));
    check({tag, ":resp_rdy"}, 64'(memreq_rdy), 64'd0);
    for (int s = 0; s < stall; s++) begin
      tick;
      check({tag, ":hold_val"}, 64'(memresp_val), 64'd1);
      check({tag, ":hold_msg"}, 64'(memresp_msg), 64'(exp));
      check({tag, ":hold_rdy"}, 64'(memreq_rdy), 64'd0);
    end
    memresp_rdy = 1'b1;
    tick;
    memresp_rdy = 1'b0;
    check({tag, ":post_val"}, 64'(memresp_val), 64'd0);
    check({tag, ":post_rdy"}, 64'(memreq_rdy), 64'd1);
  endtask

  // Accept a request, then reset after 'delay' further edges (while still in WAIT or on its exit edge).
  task automatic reset_in_wait(input string tag, input logic [2:0] t, input logic [31:0] a,
                               input logic [31:0] d, input int delay);
    memreq_val = 1'b1;
    memreq_msg = '{type_: t, opaque: 8'hEE, addr: a, len: 2'd0, data: d};
    tick;
    memreq_val = 1'b0; memreq_msg = '0;
    for (int i = 0; i < delay; i++) tick;
    reset = 1'b1;
    tick;
    check({tag, ":rst_val"}, 64'(memresp_val), 64'd0);
    check({tag, ":rst_rdy"}, 64'(memreq_rdy), 64'd1);
    check({tag, ":rst_msg"}, 64'(memresp_msg), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check({tag, ":after_val"}, 64'(memresp_val), 64'd0);
      check({tag, ":after_rdy"}, 64'(memreq_rdy), 64'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  t;
    logic [31:0] a, d, e;
    logic [1:0]  len;

    tbl[0]  = '{3'd0, 8'h3A, 32'h0000_0014, 2'd0, 32'h0,         0, 32'hDEADBEEF};
    tbl[1]  = '{3'd1, 8'h01, 32'h0000_0100, 2'd0, 32'h12345678,  0, 32'h0};
    tbl[2]  = '{3'd0, 8'h02, 32'h0000_0100, 2'd0, 32'h0,         0, 32'h12345678};
    tbl[3]  = '{3'd1, 8'h03, 32'h0000_0020, 2'd2, 32'h0000ABCD,  0, 32'h0};
    tbl[4]  = '{3'd0, 8'h04, 32'h0000_0020, 2'd0, 32'h0,         0, 32'hFFFFABCD};
    tbl[5]  = '{3'd1, 8'h05, 32'h0000_0400, 2'd0, 32'hCAFEF00D,  0, 32'h0};
    tbl[6]  = '{3'd0, 8'h06, 32'h0000_0000, 2'd0, 32'h0,         5, 32'hCAFEF00D};
    tbl[7]  = '{3'd1, 8'h07, 32'h0000_0023, 2'd1, 32'h00000077,  1, 32'h0};
    tbl[8]  = '{3'd0, 8'h08, 32'h0000_0020, 2'd0, 32'h0,         0, 32'hFFFFAB77};
    tbl[9]  = '{3'd5, 8'h09, 32'h0000_0014, 2'd0, 32'h0,         2, 32'hDEADBEEF};
    tbl[10] = '{3'd1, 8'h0A, 32'h0000_0100, 2'd3, 32'hAABBCCDD,  0, 32'h0};
    tbl[11] = '{3'd0, 8'h0B, 32'h0000_0100, 2'd0, 32'h0,         0, 32'h12BBCCDD};

    tick;
    tick;
    check("reset:req_rdy", 64'(memreq_rdy), 64'd1);
    check("reset:resp_val", 64'(memresp_val), 64'd0);
    check("reset:resp_msg", 64'(memresp_msg), 64'd0);
    reset = 1'b0;
    tick;

    for (int i = 0; i < NW; i++) preload(32'(i * 4), $urandom);
    preload(32'h14, 32'hDEADBEEF);
    preload(32'h20, 32'hFFFFFFFF);

    for (int i = 0; i < 12; i++) begin
      transact($sformatf("vec%0d", i), tbl[i].t, tbl[i].op, tbl[i].addr, tbl[i].len,
               tbl[i].data, tbl[i].stall, tbl[i].exp_data, 1'b0);
      if (tbl[i].t == MEM_WRITE) model_write(tbl[i].addr, tbl[i].len, tbl[i].data);
    end

    // Backdoor and read of the same word on one accept edge: read sees init_data.
    init_wen = 1'b1; init_addr = 32'h40; init_data = 32'h5A5A5A5A;
    model[widx(32'h40)] = 32'h5A5A5A5A;
    transact("bd_same_edge", 3'd0, 8'h10, 32'h40, 2'd0, 32'h0, 0, 32'h5A5A5A5A, 1'b0);

    // Backdoor while busy is ignored.
    transact("bd_in_wait", 3'd0, 8'h11, 32'h14, 2'd0, 32'h0, 0, 32'hDEADBEEF, 1'b1);
    transact("bd_in_wait_rd", 3'd0, 8'h12, 32'h14, 2'd0, 32'h0, 0, 32'hDEADBEEF, 1'b0);

    // Reset mid-flight: no response, dropped write leaves memory untouched.
    reset_in_wait("rst_rd", 3'd0, 32'h14, 32'h0, 0);
    transact("rst_rd_after", 3'd0, 8'h13, 32'h14, 2'd0, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    reset_in_wait("rst_wr", 3'd1, 32'h14, 32'h0BADF00D, 1);
    transact("rst_wr_after", 3'd0, 8'h14, 32'h14, 2'd0, 32'h0, 0, 32'hDEADBEEF, 1'b0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) preload($urandom, $urandom);
      if ($urandom_range(0, 9) < 4)       t = MEM_WRITE;
      else if ($urandom_range(0, 9) == 0) t = 3'($urandom_range(2, 7));
      else                                t = MEM_READ;
      a   = $urandom;
      d   = $urandom;
      len = 2'($urandom_range(0, 3));
      e   = (t == MEM_WRITE) ? 32'd0 : model[widx(a)];
      transact($sformatf("rnd%0d", i), t, 8'($urandom), a, len, d,
               $urandom_range(0, 3), e, 1'b0);
      if (t == MEM_WRITE) model_write(a, len, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
